// File: rtl/uart_prog_loader.sv
// UART boot loader: receives 8N1 bytes, packs them little-endian into
// 32-bit words and writes them through the memory UPG port.
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 87,
   parameter int WORDS        = 16384,
   parameter int IDLE_CLKS    = 2000000
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rx,
   output logic        upg_wen_o,
   output logic [13:0] upg_adr_o,
   output logic [31:0] upg_dat_o,
   output logic        upg_done_o,
   output logic        busy,
   output logic        frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(IDLE_CLKS + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CLKS);
   localparam logic [13:0]   LAST_ADR = 14'(WORDS - 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_RECV,
      LD_DONE
   } ld_state_t;

   logic          rx_meta;
   logic          rx_sync;
   rx_state_t     rx_state;
   rx_state_t     rx_state_n;
   logic [CW-1:0] rx_cnt;
   logic [CW-1:0] rx_cnt_n;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_n;
   logic [7:0]    shreg;
   logic [7:0]    shreg_n;
   logic          byte_valid;
   logic          stop_bad;

   ld_state_t     ld_state;
   ld_state_t     ld_state_n;
   logic [1:0]    idx;
   logic [31:0]   word;
   logic          wrote;
   logic [IW-1:0] idle_cnt;
   logic          last_wr;
   logic          timeout;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + CW'(1);
      bit_idx_n  = bit_idx;
      shreg_n    = shreg;
      byte_valid = 1'b0;
      stop_bad   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (!rx_sync) rx_state_n = RX_START;
         end
         RX_START: begin
            if (rx_cnt == HALF_M1) begin
               rx_cnt_n   = '0;
               bit_idx_n  = '0;
               rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == FULL_M1) begin
               rx_cnt_n  = '0;
               shreg_n   = {rx_sync, shreg[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == FULL_M1) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_IDLE;
               byte_valid = rx_sync;
               stop_bad   = !rx_sync;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   assign last_wr = upg_wen_o && (upg_adr_o == LAST_ADR);
   assign timeout = (idle_cnt == IDLE_MAX) && wrote;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) ld_state <= LD_IDLE;
      else        ld_state <= ld_state_n;
   end

   always_comb begin
      ld_state_n = ld_state;
      if (start) begin
         ld_state_n = LD_RECV;
      end else if (ld_state == LD_RECV) begin
         if (last_wr || timeout) ld_state_n = LD_DONE;
      end
   end

   // A start pulse takes priority over a byte landing in the same cycle.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         upg_wen_o <= 1'b0;
         upg_adr_o <= '0;
         upg_dat_o <= '0;
         frame_err <= 1'b0;
         idx       <= '0;
         word      <= '0;
         wrote     <= 1'b0;
         idle_cnt  <= '0;
      end else if (start) begin
         upg_wen_o <= 1'b0;
         upg_adr_o <= '0;
         frame_err <= 1'b0;
         idx       <= '0;
         word      <= '0;
         wrote     <= 1'b0;
         idle_cnt  <= '0;
      end else begin
         upg_wen_o <= 1'b0;
         if (stop_bad) frame_err <= 1'b1;
         if (upg_wen_o) begin
            wrote <= 1'b1;
            if (upg_adr_o != LAST_ADR) upg_adr_o <= upg_adr_o + 14'd1;
         end
         if (busy && byte_valid) begin
            word[{idx, 3'b000} +: 8] <= shreg;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
               upg_wen_o <= 1'b1;
               upg_dat_o <= {shreg, word[23:0]};
            end
         end
         if (busy && rx_state == RX_IDLE && rx_sync) begin
            if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IW'(1);
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   assign busy       = (ld_state == LD_RECV);
   assign upg_done_o = (ld_state == LD_DONE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader with small parameters.
module tb_uart_prog_loader;

   localparam int CPB = 4;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        rx = 1'b1;
   logic        upg_wen_o;
   logic [13:0] upg_adr_o;
   logic [31:0] upg_dat_o;
   logic        upg_done_o;
   logic        busy;
   logic        frame_err;

   typedef struct {
      logic [13:0] adr;
      logic [31:0] dat;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   uart_prog_loader #(
      .CLKS_PER_BIT(CPB),
      .WORDS(4),
      .IDLE_CLKS(200)
   ) dut (
      .clock(clock),
      .rst_n(rst_n),
      .start(start),
      .rx(rx),
      .upg_wen_o(upg_wen_o),
      .upg_adr_o(upg_adr_o),
      .upg_dat_o(upg_dat_o),
      .upg_done_o(upg_done_o),
      .busy(busy),
      .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      exp_t e;
      if (rst_n && upg_wen_o) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe got adr=%0d dat=%h, required no strobe",
                     upg_adr_o, upg_dat_o);
         end else begin
            e = exp_q.pop_front();
            if (upg_adr_o !== e.adr || upg_dat_o !== e.dat) begin
               fails++;
               $display("FAIL strobe got adr=%0d dat=%h, required adr=%0d dat=%h",
                        upg_adr_o, upg_dat_o, e.adr, e.dat);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      rx = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(CPB);
      end
      rx = stop_bit;
      wait_cyc(CPB);
      rx = 1'b1;
      wait_cyc(2 * CPB);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
   endtask

   task automatic push(input logic [13:0] a, input logic [31:0] d);
      exp_t e;
      e.adr = a;
      e.dat = d;
      exp_q.push_back(e);
   endtask

   task automatic check_drain(input string name);
      wait_cyc(4);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain got %0d pending strobes, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx = 1'b1;
      wait_cyc(3);
      tests++;
      if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy, frame_err} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got wen=%b adr=%0d dat=%h done=%b busy=%b ferr=%b, required all 0",
                  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy, frame_err);
      end
      rst_n = 1'b1;
      wait_cyc(2);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      tests++;
      if (busy !== 1'b0 || upg_done_o !== 1'b0) begin
         fails++;
         $display("FAIL no_start_idle got busy=%b done=%b, required 0 0", busy, upg_done_o);
      end
      check_drain("no_start");
   endtask

   task automatic test_single_word();
      pulse_start();
      push(14'd0, 32'h12345678);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      tests++;
      if (busy !== 1'b1 || upg_done_o !== 1'b0) begin
         fails++;
         $display("FAIL single_status got busy=%b done=%b, required 1 0", busy, upg_done_o);
      end
      tests++;
      if (upg_adr_o !== 14'd1 || upg_dat_o !== 32'h12345678) begin
         fails++;
         $display("FAIL single_hold got adr=%0d dat=%h, required 1 12345678", upg_adr_o, upg_dat_o);
      end
      check_drain("single");
   endtask

   task automatic test_full_image();
      logic [7:0] b;
      pulse_start();
      for (int w = 0; w < 4; w++) begin
         b = 8'(4 * w);
         push(14'(w), {b + 8'd3, b + 8'd2, b + 8'd1, b});
      end
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      tests++;
      if (upg_done_o !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL full_done got done=%b busy=%b, required 1 0", upg_done_o, busy);
      end
      send_byte(8'h10);
      tests++;
      if (upg_dat_o !== 32'h0F0E0D0C || upg_done_o !== 1'b1) begin
         fails++;
         $display("FAIL full_after got dat=%h done=%b, required 0f0e0d0c 1", upg_dat_o, upg_done_o);
      end
      check_drain("full");
   endtask

   task automatic test_frame_err();
      pulse_start();
      tests++;
      if (frame_err !== 1'b0 || upg_done_o !== 1'b0) begin
         fails++;
         $display("FAIL restart_clear got ferr=%b done=%b, required 0 0", frame_err, upg_done_o);
      end
      send_byte(8'hAA, 1'b0);
      wait_cyc(8);
      tests++;
      if (frame_err !== 1'b1) begin
         fails++;
         $display("FAIL frame_err got %b, required 1", frame_err);
      end
      push(14'd0, 32'h44332211);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      check_drain("frame");
   endtask

   task automatic test_idle_timeout();
      pulse_start();
      push(14'd0, 32'hDDCCBBAA);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      send_byte(8'h01);
      send_byte(8'h02);
      wait_cyc(260);
      tests++;
      if (upg_done_o !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL timeout_done got done=%b busy=%b, required 1 0", upg_done_o, busy);
      end
      check_drain("timeout");
      pulse_start();
      send_byte(8'h05);
      send_byte(8'h06);
      wait_cyc(300);
      tests++;
      if (upg_done_o !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL timeout_noword got done=%b busy=%b, required 0 1", upg_done_o, busy);
      end
      check_drain("noword");
   endtask

   task automatic test_glitch_reset();
      pulse_start();
      rx = 1'b0;
      wait_cyc(1);
      rx = 1'b1;
      wait_cyc(20);
      push(14'd0, 32'h04030201);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      tests++;
      if (frame_err !== 1'b0) begin
         fails++;
         $display("FAIL glitch_ferr got %b, required 0", frame_err);
      end
      check_drain("glitch");
      rx = 1'b0;
      wait_cyc(CPB);
      rx = 1'b0;
      wait_cyc(2 * CPB);
      wait_cyc(CPB / 2);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy, frame_err} !== '0) begin
         fails++;
         $display("FAIL midreset_outputs got wen=%b adr=%0d dat=%h done=%b busy=%b ferr=%b, required all 0",
                  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy, frame_err);
      end
      rx = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(4);
      pulse_start();
      push(14'd0, 32'h12345678);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      tests++;
      if (busy !== 1'b1 || upg_done_o !== 1'b0 || upg_adr_o !== 14'd1) begin
         fails++;
         $display("FAIL after_reset got busy=%b done=%b adr=%0d, required 1 0 1",
                  busy, upg_done_o, upg_adr_o);
      end
      check_drain("after_reset");
   endtask

   initial begin
      wait_cyc(1);
      test_reset();
      test_single_word();
      test_full_image();
      test_frame_err();
      test_idle_timeout();
      test_glitch_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
